// File: rtl/reset_seq_ctrl_if.sv
// rtl/reset_seq_ctrl_if.sv - reset request inputs and staged reset outputs of reset_seq_ctrl
interface reset_seq_ctrl_if;
    logic       btn_rst_n;
    logic       sw_rst_req;
    logic       mem_rst_n;
    logic       reg_rst_n;
    logic       cpu_rst_n;
    logic       sys_ready;
    logic [1:0] rst_cause;

    modport master (
        output btn_rst_n, sw_rst_req,
        input  mem_rst_n, reg_rst_n, cpu_rst_n, sys_ready, rst_cause
    );

    modport slave (
        input  btn_rst_n, sw_rst_req,
        output mem_rst_n, reg_rst_n, cpu_rst_n, sys_ready, rst_cause
    );
endinterface

// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - staged reset release sequencer with button debounce and warm reset
module reset_seq_ctrl #(
    parameter logic [7:0]  STAGE_DELAY     = 8'd4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic              clk,
    input  logic              async_rst_n,
    reset_seq_ctrl_if.slave   rst_if
);
    typedef enum logic [2:0] {
        HOLD = 3'd0,
        MEM  = 3'd1,
        REGS = 3'd2,
        CPU  = 3'd3,
        RUN  = 3'd4
    } state_t;

    localparam logic [7:0]  STAGE_LAST = STAGE_DELAY - 8'd1;
    localparam logic [15:0] DEB_LAST   = DEBOUNCE_CYCLES - 16'd1;

    state_t      state_q, state_d;
    logic [7:0]  stage_cnt_q, stage_cnt_d;
    logic        btn_meta_q, btn_sync_q;
    logic        btn_deb_q, btn_deb_prev_q;
    logic [15:0] deb_cnt_q;
    logic        mem_q, reg_q, cpu_q, ready_q;
    logic [1:0]  cause_q, cause_d;
    logic        btn_evt, warm_hold;

    // A low debounced button keeps the sequence parked, but only its falling edge records a cause.
    assign btn_evt   = btn_deb_prev_q & ~btn_deb_q;
    assign warm_hold = ~btn_deb_q | rst_if.sw_rst_req;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            btn_meta_q     <= 1'b1;
            btn_sync_q     <= 1'b1;
            btn_deb_q      <= 1'b1;
            btn_deb_prev_q <= 1'b1;
            deb_cnt_q      <= '0;
        end else begin
            btn_meta_q     <= rst_if.btn_rst_n;
            btn_sync_q     <= btn_meta_q;
            btn_deb_prev_q <= btn_deb_q;
            if (btn_sync_q != btn_deb_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    btn_deb_q <= btn_sync_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 16'd1;
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_cnt_d = stage_cnt_q;
        cause_d     = cause_q;
        if (btn_evt) begin
            cause_d = 2'b01;
        end else if (rst_if.sw_rst_req) begin
            cause_d = 2'b10;
        end
        if (warm_hold) begin
            state_d     = HOLD;
            stage_cnt_d = '0;
        end else begin
            case (state_q)
                HOLD, MEM, REGS, CPU: begin
                    if (stage_cnt_q == STAGE_LAST) begin
                        stage_cnt_d = '0;
                        case (state_q)
                            HOLD:    state_d = MEM;
                            MEM:     state_d = REGS;
                            REGS:    state_d = CPU;
                            default: state_d = RUN;
                        endcase
                    end else begin
                        stage_cnt_d = stage_cnt_q + 8'd1;
                    end
                end
                RUN: stage_cnt_d = '0;
                default: begin
                    state_d     = HOLD;
                    stage_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= HOLD;
            stage_cnt_q <= '0;
            cause_q     <= 2'b00;
            mem_q       <= 1'b0;
            reg_q       <= 1'b0;
            cpu_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_cnt_q <= stage_cnt_d;
            cause_q     <= cause_d;
            mem_q       <= (state_d == MEM) || (state_d == REGS) || (state_d == CPU) || (state_d == RUN);
            reg_q       <= (state_d == REGS) || (state_d == CPU) || (state_d == RUN);
            cpu_q       <= (state_d == CPU) || (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign rst_if.mem_rst_n = mem_q;
    assign rst_if.reg_rst_n = reg_q;
    assign rst_if.cpu_rst_n = cpu_q;
    assign rst_if.sys_ready = ready_q;
    assign rst_if.rst_cause = cause_q;
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - randomized check of reset_seq_ctrl against an elapsed-time reference model
module tb_reset_seq_ctrl;
    localparam int SD  = 4;
    localparam int DEB = 10;

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;
    always #5 clk = ~clk;

    reset_seq_ctrl_if rif ();
    reset_seq_ctrl_if rif1 ();

    reset_seq_ctrl #(.STAGE_DELAY(8'd4), .DEBOUNCE_CYCLES(16'd10)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .rst_if(rif.slave)
    );
    reset_seq_ctrl #(.STAGE_DELAY(8'd1), .DEBOUNCE_CYCLES(16'd10)) dut_sd1 (
        .clk(clk), .async_rst_n(async_rst_n), .rst_if(rif1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: button path as a 2-deep delay plus a stable-run counter; stages as edges since release.
    logic       m_s1, m_s2, m_deb, m_deb_prev;
    int         m_run;
    int         m_t;
    logic [1:0] m_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_deb_prev = 1'b1;
        m_run = 0; m_t = 0; m_cause = 2'b00;
    endtask

    task automatic model_edge(input logic b, input logic s);
        logic hold, evt, old_deb;
        hold = !m_deb || s;
        evt  = !m_deb && m_deb_prev;
        if (hold) m_t = 0;
        else if (m_t < 4*SD) m_t++;
        if (evt) m_cause = 2'b01;
        else if (s) m_cause = 2'b10;
        old_deb = m_deb;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_deb_prev = old_deb;
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic check_outs();
        check("mem_rst_n", {31'd0, rif.mem_rst_n}, {31'd0, m_t >= SD});
        check("reg_rst_n", {31'd0, rif.reg_rst_n}, {31'd0, m_t >= 2*SD});
        check("cpu_rst_n", {31'd0, rif.cpu_rst_n}, {31'd0, m_t >= 3*SD});
        check("sys_ready", {31'd0, rif.sys_ready}, {31'd0, m_t >= 4*SD});
        check("rst_cause", {30'd0, rif.rst_cause}, {30'd0, m_cause});
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic b, input logic s);
        rif.btn_rst_n  = b;
        rif.sw_rst_req = s;
        @(posedge clk);
        model_edge(b, s);
        #1;
        check_outs();
    endtask

    task automatic areset();
        #2;
        async_rst_n = 1'b0;
        #1;
        check("async_mem", {31'd0, rif.mem_rst_n}, 32'd0);
        check("async_reg", {31'd0, rif.reg_rst_n}, 32'd0);
        check("async_cpu", {31'd0, rif.cpu_rst_n}, 32'd0);
        check("async_ready", {31'd0, rif.sys_ready}, 32'd0);
        check("async_cause", {30'd0, rif.rst_cause}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        check_outs();
    endtask

    initial begin
        int btn_left;
        int sw_left;
        bit found;
        logic b, s;
        rif.btn_rst_n   = 1'b1;
        rif.sw_rst_req  = 1'b0;
        rif1.btn_rst_n  = 1'b1;
        rif1.sw_rst_req = 1'b0;
        model_reset();
        #2;
        check_outs();
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;

        for (int e = 1; e <= 18; e++) begin
            cycle(1'b1, 1'b0);
            if (e <= 5) begin
                check("sd1_mem", {31'd0, rif1.mem_rst_n}, {31'd0, e >= 1});
                check("sd1_reg", {31'd0, rif1.reg_rst_n}, {31'd0, e >= 2});
                check("sd1_cpu", {31'd0, rif1.cpu_rst_n}, {31'd0, e >= 3});
                check("sd1_ready", {31'd0, rif1.sys_ready}, {31'd0, e >= 4});
            end
        end
        check("por_ready", {31'd0, rif.sys_ready}, 32'd1);

        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0);
        check("glitch_ignored", {31'd0, rif.sys_ready}, 32'd1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        check("btn_cause", {30'd0, rif.rst_cause}, 32'd1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);

        cycle(1'b1, 1'b1);
        check("sw_cause", {30'd0, rif.rst_cause}, 32'd2);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 1'b0);
            if (!m_deb) found = 1'b1;
        end
        check("deb_fall_seen", {31'd0, found}, 32'd1);
        cycle(1'b0, 1'b1);
        check("simul_cause", {30'd0, rif.rst_cause}, 32'd1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);

        areset();
        for (int i = 0; i < SD + 2; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("mem_sw_drop", {31'd0, rif.mem_rst_n}, 32'd0);
        for (int i = 0; i < 2*SD + 1; i++) cycle(1'b1, 1'b0);
        check("in_regs", {31'd0, rif.reg_rst_n}, 32'd1);
        areset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        btn_left = 0;
        sw_left  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_left == 0 && $urandom_range(0, 59) == 0) btn_left = $urandom_range(1, 25);
            b = (btn_left == 0);
            if (btn_left > 0) btn_left--;
            if (sw_left == 0 && $urandom_range(0, 79) == 0) sw_left = $urandom_range(1, 3);
            s = (sw_left > 0);
            if (sw_left > 0) sw_left--;
            if ($urandom_range(0, 599) == 0) areset();
            else cycle(b, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 The block SHALL have parameter STAGE_DELAY, default 8'd4, meaning cycles per release stage (legal 1..255).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning cycles the button must be stable before it is accepted (legal 1..65535).
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port async_rst_n  input  1  asynchronous active-low reset (power-on); assertion is asynchronous, deassertion is already synchronized to clk.
REQ-005 Port btn_rst_n  input  1  raw manual reset button, active-low, asynchronous to clk.
REQ-006 Port sw_rst_req  input  1  software warm-reset request, single-cycle pulse, synchronous to clk.
REQ-007 Port mem_rst_n  output  1  memory-subsystem reset, active-low, registered.
REQ-008 Port reg_rst_n  output  1  register-file/ALU reset, active-low, registered.
REQ-009 Port cpu_rst_n  output  1  control-unit/PC reset, active-low, registered.
REQ-010 Port sys_ready  output  1  high when all stages are released, registered.
REQ-011 Port rst_cause  output  2  last reset source: 00 power-on, 01 button, 10 software, 11 unused.

Function
REQ-012 btn_rst_n SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-013 Debounce: 16-bit counter SHALL increment while the synced button differs from the debounced value, clear when they match, and update the debounced value on the cycle the count reaches DEBOUNCE_CYCLES-1, clearing the counter.
REQ-014 A button event SHALL be a 1-to-0 transition of the debounced value; a debounced value of 0 SHALL hold the FSM in HOLD.
REQ-015 FSM states SHALL be HOLD, MEM, REGS, CPU, and RUN, encoded in 3 bits; unused encodings SHALL go to HOLD on the next edge.
REQ-016 An 8-bit stage counter SHALL increment each cycle in HOLD/MEM/REGS/CPU. At STAGE_DELAY-1, the FSM SHALL advance HOLD->MEM->REGS->CPU->RUN and the counter SHALL clear. The counter SHALL hold 0 in RUN.
REQ-017 Outputs SHALL be registered from the next state:
- mem_rst_n=1 in MEM/REGS/CPU/RUN
- reg_rst_n=1 in REGS/CPU/RUN
- cpu_rst_n=1 in CPU/RUN
- sys_ready=1 in RUN only
- all other cases 0
REQ-018 Release latency after async_rst_n deassertion SHALL be, counted in rising edges:
- mem_rst_n at STAGE_DELAY
- reg_rst_n at 2*STAGE_DELAY
- cpu_rst_n at 3*STAGE_DELAY
- sys_ready at 4*STAGE_DELAY
This ordering SHALL be kept with no overlap or skip.
REQ-019 A button event or sw_rst_req=1 in any state SHALL, on the next edge, force HOLD, clear the counter, and drive all resets low and sys_ready low.
REQ-020 On a warm reset, rst_cause SHALL become 01 for a button event or 10 for software; if both occur in the same cycle, button wins (01).
REQ-021 A warm reset during HOLD SHALL restart the count from 0.
REQ-022 sw_rst_req held high for multiple cycles SHALL keep the FSM in HOLD with the counter at 0.
REQ-023 Release order SHALL be mem_rst_n, then reg_rst_n, then cpu_rst_n. Reassertion on a warm reset SHALL be simultaneous for all three.

Reset
REQ-024 async_rst_n=0 SHALL immediately, without a clock, set: state HOLD, both counters 0, synchronizer and debounced value 1, mem_rst_n/reg_rst_n/cpu_rst_n 0, sys_ready 0, rst_cause 00.
REQ-025 async_rst_n asserted mid-sequence or in RUN SHALL override all other inputs, and rst_cause SHALL return to 00.

Verification
REQ-026 POR (STAGE_DELAY=4, button high): release async_rst_n -> mem_rst_n rises at edge 4, reg_rst_n at 8, cpu_rst_n at 12, sys_ready at 16; rst_cause=00.
REQ-027 Button debounce (DEBOUNCE_CYCLES=10): in RUN, 5-cycle low glitch -> no change. Low for 20 cycles -> all resets low 1 cycle after the debounced fall (2 sync + 10 cycles), rst_cause=01. Re-release sequences after the debounced rise.
REQ-028 Software reset: in RUN, 1-cycle sw_rst_req -> next edge all outputs 0, rst_cause=10; sys_ready returns after 4*STAGE_DELAY edges.
REQ-029 Simultaneous event: debounced button fall and sw_rst_req in the same cycle -> rst_cause=01. sw_rst_req in MEM state with counter=2 -> HOLD with counter 0, mem_rst_n=0.
REQ-030 Async reset mid-operation: assert async_rst_n in REGS state between clock edges -> outputs 0 before the next edge, rst_cause=00. STAGE_DELAY=1 -> release edges 1, 2, 3, 4.
